// File: rtl/fb_ifetch_pkg.sv
// Shared types and constants for the fb_ifetch instruction-fetch stage.
// FB_IF_ALIGN_CHECK_EN adds the terminal HALT state for misaligned branches.
package fb_ifetch_pkg;

    localparam int unsigned FB_32BITS = 32;
    localparam logic [FB_32BITS-1:0] FB_NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        FB_IF_FETCH = 3'd0,
        FB_IF_WAIT  = 3'd1,
        FB_IF_DROP  = 3'd2,
        FB_IF_HOLD  = 3'd3
`ifdef FB_IF_ALIGN_CHECK_EN
        ,
        FB_IF_HALT  = 3'd4
`endif
    } fb_if_state_e;

    // Sequential PC increment; wraps modulo 2^32
    function automatic logic [FB_32BITS-1:0] fb_pc_inc(input logic [FB_32BITS-1:0] pc);
        return pc + FB_32BITS'(4);
    endfunction

endpackage

// File: rtl/fb_ifetch_pcgen.sv
// Program counter register and next-PC select (reset, +4, branch).
// With FB_IF_ALIGN_CHECK_EN, misaligned branch targets are rejected and flagged.
module fb_ifetch_pcgen
    import fb_ifetch_pkg::*;
#(
    parameter logic [FB_32BITS-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 br_en_i,
    input  logic [FB_32BITS-1:0] br_pc_i,
    input  logic                 inc_en_i,
    output logic [FB_32BITS-1:0] pc_o,
    output logic                 bad_br_c,
    output logic                 misalign_o
);

    logic [FB_32BITS-1:0] pc_q;
    logic [FB_32BITS-1:0] pc_d;
    logic [FB_32BITS-1:0] tgt;

    always_comb begin
        bad_br_c = 1'b0;
        tgt      = br_pc_i & ~FB_32BITS'(3);
`ifdef FB_IF_ALIGN_CHECK_EN
        bad_br_c = br_en_i && (br_pc_i[1:0] != 2'b00);
        tgt      = br_pc_i;
`endif
        pc_d = pc_q;
        if (br_en_i) begin
            if (!bad_br_c) begin
                pc_d = tgt;
            end
        end else if (inc_en_i) begin
            pc_d = fb_pc_inc(pc_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

`ifdef FB_IF_ALIGN_CHECK_EN
    logic misalign_q;

    // Sticky until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_q | bad_br_c;
        end
    end

    assign misalign_o = misalign_q;
`else
    assign misalign_o = 1'b0;
`endif

    assign pc_o = pc_q;

endmodule

// File: rtl/fb_ifetch.sv
// Instruction-fetch stage: one outstanding imem read, lock buffering, branch redirect.
// FB_IF_ALIGN_CHECK_EN enables the misaligned-branch HALT behaviour.
module fb_ifetch
    import fb_ifetch_pkg::*;
#(
    parameter logic [FB_32BITS-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lock,
    input  logic                 branch_en,
    input  logic [FB_32BITS-1:0] branch_pc,
    output logic                 imem_req,
    output logic [FB_32BITS-1:0] imem_addr,
    input  logic                 imem_rvalid,
    input  logic [FB_32BITS-1:0] imem_rdata,
    output logic                 if_we,
    output logic [FB_32BITS-1:0] if_pc,
    output logic [FB_32BITS-1:0] if_inst,
    output logic                 if_misalign
);

    fb_if_state_e         state_q;
    fb_if_state_e         state_d;
    logic [FB_32BITS-1:0] hold_q;
    logic [FB_32BITS-1:0] hold_d;
    logic [FB_32BITS-1:0] pc;
    logic [FB_32BITS-1:0] inst_c;
    logic                 req_c;
    logic                 we_c;
    logic                 inc_en;
    logic                 br_take;
    logic                 bad_br_c;
    logic                 halted;

`ifdef FB_IF_ALIGN_CHECK_EN
    assign halted = (state_q == FB_IF_HALT);
`else
    assign halted = 1'b0;
`endif

    // A halted stage ignores further redirects
    assign br_take = branch_en && !halted;

    fb_ifetch_pcgen #(
        .RESET_PC (RESET_PC)
    ) u_pcgen (
        .clk        (clk),
        .rst        (rst),
        .br_en_i    (br_take),
        .br_pc_i    (branch_pc),
        .inc_en_i   (inc_en),
        .pc_o       (pc),
        .bad_br_c   (bad_br_c),
        .misalign_o (if_misalign)
    );

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        req_c   = 1'b0;
        we_c    = 1'b0;
        inst_c  = imem_rdata;
        inc_en  = 1'b0;
        case (state_q)
            FB_IF_FETCH: begin
                if (!br_take) begin
                    req_c   = 1'b1;
                    state_d = FB_IF_WAIT;
                end
            end
            FB_IF_WAIT: begin
                if (br_take) begin
                    state_d = imem_rvalid ? FB_IF_FETCH : FB_IF_DROP;
                end else if (imem_rvalid) begin
                    if (lock) begin
                        hold_d  = imem_rdata;
                        state_d = FB_IF_HOLD;
                    end else begin
                        we_c    = 1'b1;
                        inc_en  = 1'b1;
                        state_d = FB_IF_FETCH;
                    end
                end
            end
            FB_IF_DROP: begin
                if (imem_rvalid) begin
                    state_d = FB_IF_FETCH;
                end
            end
            FB_IF_HOLD: begin
                if (br_take) begin
                    state_d = FB_IF_FETCH;
                end else if (!lock) begin
                    we_c    = 1'b1;
                    inst_c  = hold_q;
                    inc_en  = 1'b1;
                    state_d = FB_IF_FETCH;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
`ifdef FB_IF_ALIGN_CHECK_EN
        if (bad_br_c) begin
            state_d = FB_IF_HALT;
        end
`endif
        // Nothing leaves the stage while reset is asserted
        if (rst) begin
            req_c = 1'b0;
            we_c  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FB_IF_FETCH;
            hold_q  <= FB_NOP;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    assign imem_req  = req_c;
    assign imem_addr = pc;
    assign if_we     = we_c;
    assign if_pc     = rst ? RESET_PC : pc;
    assign if_inst   = we_c ? inst_c : FB_NOP;

endmodule

// File: tb/tb_fb_ifetch.sv
// Scoreboard bench for fb_ifetch: directed cycle script, decoupled request/delivery monitor.
module tb_fb_ifetch;
    import fb_ifetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lock = 1'b0;
    logic        branch_en = 1'b0;
    logic [31:0] branch_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_we;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_misalign;

    always #5 clk = ~clk;

    fb_ifetch #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .lock        (lock),
        .branch_en   (branch_en),
        .branch_pc   (branch_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_we       (if_we),
        .if_pc       (if_pc),
        .if_inst     (if_inst),
        .if_misalign (if_misalign)
    );

    typedef struct {
        int          c;
        logic [31:0] addr;
    } req_t;

    typedef struct {
        int          c;
        logic [31:0] pc;
        logic [31:0] inst;
    } del_t;

    req_t req_q[$];
    del_t del_q[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: every request and delivery must match the next scoreboard entry
    always @(negedge clk) begin
        req_t er;
        del_t ed;
        if (imem_req === 1'b1) begin
            if (req_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_req: got addr %h, required no request (cycle %0d)", imem_addr, cyc);
            end else begin
                er = req_q.pop_front();
                chk("req_cycle", 32'(cyc), 32'(er.c));
                chk("req_addr", imem_addr, er.addr);
            end
        end
        if (if_we === 1'b1) begin
            if (del_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_we: got pc %h inst %h, required no delivery (cycle %0d)", if_pc, if_inst, cyc);
            end else begin
                ed = del_q.pop_front();
                chk("we_cycle", 32'(cyc), 32'(ed.c));
                chk("we_pc", if_pc, ed.pc);
                chk("we_inst", if_inst, ed.inst);
            end
        end else begin
            chk("idle_inst", if_inst, FB_NOP);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        lock        = 1'b0;
        branch_en   = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
    endtask

    task automatic exp_req(input logic [31:0] a);
        req_t e;
        e.c    = cyc;
        e.addr = a;
        req_q.push_back(e);
    endtask

    task automatic exp_del(input logic [31:0] p, input logic [31:0] d);
        del_t e;
        e.c    = cyc;
        e.pc   = p;
        e.inst = d;
        del_q.push_back(e);
    endtask

    task automatic respond(input logic [31:0] d);
        imem_rvalid = 1'b1;
        imem_rdata  = d;
    endtask

    task automatic branch(input logic [31:0] t);
        branch_en = 1'b1;
        branch_pc = t;
    endtask

    initial begin
        step();
        step();
        @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_we", 32'(if_we), 32'd0);
        chk("rst_pc", if_pc, 32'h0000_0000);
        chk("rst_inst", if_inst, FB_NOP);
        chk("rst_misalign", 32'(if_misalign), 32'd0);

        // Sequential fetch, memory answering the next cycle
        step(); rst = 1'b0; exp_req(32'h0);
        step(); respond(32'h0000_0093); exp_del(32'h0, 32'h0000_0093);
        step(); exp_req(32'h4);
        step(); respond(32'h0010_0113); exp_del(32'h4, 32'h0010_0113);
        step(); exp_req(32'h8);
        step(); respond(32'h0020_0193); exp_del(32'h8, 32'h0020_0193);
        step(); exp_req(32'hC);

        // Response arrives under lock, delivered once when lock drops
        step(); lock = 1'b1;
        step(); lock = 1'b1; respond(32'hDEAD_BEEF);
        step(); lock = 1'b1;
        step(); exp_del(32'hC, 32'hDEAD_BEEF);
        step(); exp_req(32'h10);

        // Branch while a request is outstanding; late response is dropped
        step(); branch(32'h100);
        step();
        step(); respond(32'h0BAD_0010);
        step(); exp_req(32'h100);

        // Branch coincident with response
        step(); respond(32'h0BAD_0100); branch(32'h200);
        step(); exp_req(32'h200);

        // Branch discards a held instruction, then a branch in FETCH
        step(); lock = 1'b1; respond(32'h0BAD_0200);
        step(); lock = 1'b1; branch(32'h300);
        step(); branch(32'hFFFF_FFFC);
        step(); exp_req(32'hFFFF_FFFC);
        step(); respond(32'h0040_0213); exp_del(32'hFFFF_FFFC, 32'h0040_0213);
        step(); exp_req(32'h0);

        // Reset while waiting; stale response right after reset is ignored
        step(); rst = 1'b1;
        @(negedge clk);
        chk("midrst_pc", if_pc, 32'h0000_0000);
        step(); rst = 1'b0; respond(32'h0BAD_0000); exp_req(32'h0);
        step(); respond(32'h0050_0293); exp_del(32'h0, 32'h0050_0293);

        // Misaligned branch target
        step(); branch(32'h102);
`ifdef FB_IF_ALIGN_CHECK_EN
        step();
        step();
        step();
        @(negedge clk);
        chk("misalign", 32'(if_misalign), 32'd1);
`else
        step(); exp_req(32'h100);
        step(); respond(32'h0060_0313); exp_del(32'h100, 32'h0060_0313);
        step(); exp_req(32'h104);
        step();
        @(negedge clk);
        chk("misalign", 32'(if_misalign), 32'd0);
`endif
        step();
        @(negedge clk);
        chk("req_left", 32'(req_q.size()), 32'd0);
        chk("del_left", 32'(del_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
